// File: rtl/draw_controller.sv
// draw_controller
//   Collects rectangle corners (or a single point) from a push-button
//   driven coordinate entry sequence, then rasterises the region one pixel
//   per clock for a VGA adapter.
//
// Ports
//   Clock      in   1  sole clock, all state on posedge
//   Reset      in   1  synchronous active-high reset
//   go         in   1  push-button level; rising edge is an event
//   data_in    in   8  coordinate captured on go events
//   colour_in  in   3  pixel colour, latched on DRAW entry
//   mode       in   1  0 = filled rectangle, 1 = single point
//   x_out      out  8  current pixel x
//   y_out      out  7  current pixel y
//   colour_out out  3  latched colour
//   plot       out  1  pixel write strobe
//   busy       out  1  high while drawing
//   done       out  1  one-cycle pulse after the last pixel
module draw_controller #(
    parameter int unsigned X_MAX = 159,
    parameter int unsigned Y_MAX = 119
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       go,
    input  logic [7:0] data_in,
    input  logic [2:0] colour_in,
    input  logic       mode,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] S_LOAD_X1 = 3'd0;
    localparam logic [2:0] S_LOAD_Y1 = 3'd1;
    localparam logic [2:0] S_LOAD_X2 = 3'd2;
    localparam logic [2:0] S_LOAD_Y2 = 3'd3;
    localparam logic [2:0] S_DRAW    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [7:0] XM = X_MAX[7:0];
    localparam logic [6:0] YM = Y_MAX[6:0];

    logic [2:0] state_q, state_d;
    logic       go_prev_q, go_prev_d;
    logic [7:0] x1_q, x1_d, x2_q, x2_d;
    logic [6:0] y1_q, y1_d, y2_q, y2_d;
    logic [7:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [6:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic [7:0] cx_q, cx_d;
    logic [6:0] cy_q, cy_d;
    logic [2:0] colour_q, colour_d;

    logic       go_evt;
    logic [7:0] x_cap;
    logic [6:0] y_raw, y_cap;
    logic [7:0] ent_xa, ent_xb;
    logic [6:0] ent_ya, ent_yb;
    logic       enter_draw;

    assign go_evt = go & ~go_prev_q;
    assign x_cap  = (data_in > XM) ? XM : data_in;
    assign y_raw  = data_in[6:0];
    assign y_cap  = (y_raw > YM) ? YM : y_raw;

    // Corners as they will be once the capture of this cycle lands; DRAW is
    // entered on the same edge as the final capture, so the bounds must be
    // formed from the value being captured rather than the registered copy.
    // From LOAD_Y1 (point mode) the second corner equals the first.
    assign ent_xa = x1_q;
    assign ent_xb = (state_q == S_LOAD_Y1) ? x1_q : x2_q;
    assign ent_ya = (state_q == S_LOAD_Y1) ? y_cap : y1_q;
    assign ent_yb = y_cap;

    always_comb begin
        state_d    = state_q;
        go_prev_d  = go;
        x1_d       = x1_q;
        y1_d       = y1_q;
        x2_d       = x2_q;
        y2_d       = y2_q;
        xmin_d     = xmin_q;
        xmax_d     = xmax_q;
        ymin_d     = ymin_q;
        ymax_d     = ymax_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        colour_d   = colour_q;
        enter_draw = 1'b0;

        case (state_q)
            S_LOAD_X1: begin
                if (go_evt) begin
                    x1_d    = x_cap;
                    state_d = S_LOAD_Y1;
                end
            end
            S_LOAD_Y1: begin
                if (go_evt) begin
                    y1_d = y_cap;
                    if (mode) begin
                        x2_d       = x1_q;
                        y2_d       = y_cap;
                        enter_draw = 1'b1;
                    end else begin
                        state_d = S_LOAD_X2;
                    end
                end
            end
            S_LOAD_X2: begin
                if (go_evt) begin
                    x2_d    = x_cap;
                    state_d = S_LOAD_Y2;
                end
            end
            S_LOAD_Y2: begin
                if (go_evt) begin
                    y2_d       = y_cap;
                    enter_draw = 1'b1;
                end
            end
            S_DRAW: begin
                // Counters stay on the final pixel so x_out/y_out hold it
                // after drawing finishes.
                if (cx_q < xmax_q) begin
                    cx_d = cx_q + 8'd1;
                end else if (cy_q < ymax_q) begin
                    cx_d = xmin_q;
                    cy_d = cy_q + 7'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_LOAD_X1;
            end
            default: begin
                state_d = S_LOAD_X1;
            end
        endcase

        if (enter_draw) begin
            state_d  = S_DRAW;
            xmin_d   = (ent_xa < ent_xb) ? ent_xa : ent_xb;
            xmax_d   = (ent_xa < ent_xb) ? ent_xb : ent_xa;
            ymin_d   = (ent_ya < ent_yb) ? ent_ya : ent_yb;
            ymax_d   = (ent_ya < ent_yb) ? ent_yb : ent_ya;
            cx_d     = (ent_xa < ent_xb) ? ent_xa : ent_xb;
            cy_d     = (ent_ya < ent_yb) ? ent_ya : ent_yb;
            colour_d = colour_in;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_LOAD_X1;
            // A go level held through reset must not count as an event.
            go_prev_q <= 1'b1;
            x1_q      <= '0;
            y1_q      <= '0;
            x2_q      <= '0;
            y2_q      <= '0;
            xmin_q    <= '0;
            xmax_q    <= '0;
            ymin_q    <= '0;
            ymax_q    <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            colour_q  <= '0;
        end else begin
            state_q   <= state_d;
            go_prev_q <= go_prev_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            x2_q      <= x2_d;
            y2_q      <= y2_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymin_q    <= ymin_d;
            ymax_q    <= ymax_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            colour_q  <= colour_d;
        end
    end

    assign x_out      = cx_q;
    assign y_out      = cy_q;
    assign colour_out = colour_q;
    assign plot       = (state_q == S_DRAW);
    assign busy       = (state_q == S_DRAW);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_draw_controller.sv
module tb_draw_controller;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       go = 1'b0;
    logic [7:0] data_in = '0;
    logic [2:0] colour_in = '0;
    logic       mode = 1'b0;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot, busy, done;

    draw_controller #(.X_MAX(159), .Y_MAX(119)) dut (
        .Clock(Clock), .Reset(Reset), .go(go), .data_in(data_in),
        .colour_in(colour_in), .mode(mode), .x_out(x_out), .y_out(y_out),
        .colour_out(colour_out), .plot(plot), .busy(busy), .done(done)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic        m;
        logic [7:0]  d0, d1, d2, d3;
        logic [2:0]  col;
        int unsigned n;
        logic [7:0]  fx;
        logic [6:0]  fy;
        logic [7:0]  lx;
        logic [6:0]  ly;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    pix_t exp_q[$];
    pix_t log_q[$];
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // Pixel monitor / scoreboard consumer
    always @(negedge Clock) begin
        if (plot === 1'b1) begin
            pix_t p, e;
            p.x = x_out; p.y = y_out; p.c = colour_out;
            log_q.push_back(p);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL plot_unexpected: got (%0d,%0d) required no plot", x_out, y_out);
            end else begin
                e = exp_q.pop_front();
                chk("pix_x", 32'(x_out), 32'(e.x));
                chk("pix_y", 32'(y_out), 32'(e.y));
                chk("pix_colour", 32'(colour_out), 32'(e.c));
                chk("busy_in_draw", 32'(busy), 32'd1);
            end
        end
    end

    function automatic logic [7:0] clx(input logic [7:0] d);
        return (d > 8'd159) ? 8'd159 : d;
    endfunction

    function automatic logic [6:0] cly(input logic [7:0] d);
        logic [6:0] t;
        t = d[6:0];
        return (t > 7'd119) ? 7'd119 : t;
    endfunction

    function automatic vec_t mk(input logic m, input logic [7:0] d0, d1, d2, d3,
                                input logic [2:0] col, input int unsigned n,
                                input logic [7:0] fx, input logic [6:0] fy,
                                input logic [7:0] lx, input logic [6:0] ly);
        vec_t v;
        v.m = m; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3; v.col = col;
        v.n = n; v.fx = fx; v.fy = fy; v.lx = lx; v.ly = ly;
        return v;
    endfunction

    task automatic push_rect(input logic [7:0] xa, input logic [6:0] ya,
                             input logic [7:0] xb, input logic [6:0] yb,
                             input logic [2:0] c);
        int lox, hix, loy, hiy;
        lox = (xa < xb) ? int'(xa) : int'(xb);
        hix = (xa < xb) ? int'(xb) : int'(xa);
        loy = (ya < yb) ? int'(ya) : int'(yb);
        hiy = (ya < yb) ? int'(yb) : int'(ya);
        for (int y = loy; y <= hiy; y++) begin
            for (int x = lox; x <= hix; x++) begin
                pix_t p;
                p.x = 8'(x); p.y = 7'(y); p.c = c;
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic go_pulse(input logic [7:0] d);
        @(negedge Clock);
        data_in = d;
        go = 1'b1;
        @(negedge Clock);
        go = 1'b0;
    endtask

    task automatic wait_done(input string nm, input logic [7:0] lx,
                             input logic [6:0] ly, input logic [2:0] lc);
        int k = 0;
        while (done !== 1'b1 && k < 100) begin
            @(negedge Clock);
            k++;
        end
        chk({nm, "_done_seen"}, 32'(done), 32'd1);
        chk({nm, "_done_plot"}, 32'(plot), 32'd0);
        chk({nm, "_done_busy"}, 32'(busy), 32'd0);
        chk({nm, "_hold_x"}, 32'(x_out), 32'(lx));
        chk({nm, "_hold_y"}, 32'(y_out), 32'(ly));
        chk({nm, "_hold_c"}, 32'(colour_out), 32'(lc));
        @(negedge Clock);
        chk({nm, "_done_width"}, 32'(done), 32'd0);
        chk({nm, "_idle_plot"}, 32'(plot), 32'd0);
        chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
        chk({nm, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int unsigned base, cnt;
        logic [7:0] x1;
        logic [6:0] y1;
        mode = v.m;
        colour_in = v.col;
        x1 = clx(v.d0);
        y1 = cly(v.d1);
        if (v.m) push_rect(x1, y1, x1, y1, v.col);
        else     push_rect(x1, y1, clx(v.d2), cly(v.d3), v.col);
        base = log_q.size();
        go_pulse(v.d0);
        go_pulse(v.d1);
        if (!v.m) begin
            go_pulse(v.d2);
            go_pulse(v.d3);
        end
        wait_done(nm, v.lx, v.ly, v.col);
        cnt = log_q.size() - base;
        chk({nm, "_count"}, cnt, v.n);
        if (cnt > 0) begin
            chk({nm, "_first_x"}, 32'(log_q[base].x), 32'(v.fx));
            chk({nm, "_first_y"}, 32'(log_q[base].y), 32'(v.fy));
            chk({nm, "_last_x"}, 32'(log_q[base+cnt-1].x), 32'(v.lx));
            chk({nm, "_last_y"}, 32'(log_q[base+cnt-1].y), 32'(v.ly));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(1'b1, 8'd5,   8'd7,   8'd0,   8'd0,   3'b100, 1, 8'd5,   7'd7,   8'd5,   7'd7);
        vecs[1] = mk(1'b0, 8'd2,   8'd3,   8'd4,   8'd4,   3'b010, 6, 8'd2,   7'd3,   8'd4,   7'd4);
        vecs[2] = mk(1'b0, 8'd4,   8'd4,   8'd2,   8'd3,   3'b001, 6, 8'd2,   7'd3,   8'd4,   7'd4);
        vecs[3] = mk(1'b1, 8'd200, 8'd127, 8'd0,   8'd0,   3'b111, 1, 8'd159, 7'd119, 8'd159, 7'd119);
        vecs[4] = mk(1'b0, 8'd158, 8'd118, 8'd200, 8'd255, 3'b011, 4, 8'd158, 7'd118, 8'd159, 7'd119);
        vecs[5] = mk(1'b0, 8'd10,  8'd0,   8'd10,  8'd0,   3'b101, 1, 8'd10,  7'd0,   8'd10,  7'd0);
        vecs[6] = mk(1'b0, 8'd0,   8'd130, 8'd3,   8'd2,   3'b110, 4, 8'd0,   7'd2,   8'd3,   7'd2);

        // Reset with go held high throughout: releasing reset must not fire.
        go = 1'b1;
        data_in = 8'd99;
        repeat (3) @(negedge Clock);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_y", 32'(y_out), 32'd0);
        chk("rst_c", 32'(colour_out), 32'd0);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        go = 1'b0;
        mode = 1'b1;
        colour_in = 3'b011;
        push_rect(8'd50, 7'd51, 8'd50, 7'd51, 3'b011);
        go_pulse(8'd50);
        go_pulse(8'd51);
        wait_done("go_thru_reset", 8'd50, 7'd51, 3'b011);

        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // go held high for 10 cycles in LOAD_X1 advances only once.
        mode = 1'b1;
        colour_in = 3'b001;
        @(negedge Clock);
        data_in = 8'd20;
        go = 1'b1;
        @(negedge Clock);
        data_in = 8'd77;
        repeat (9) @(negedge Clock);
        go = 1'b0;
        push_rect(8'd20, 7'd21, 8'd20, 7'd21, 3'b001);
        go_pulse(8'd21);
        wait_done("go_held", 8'd20, 7'd21, 3'b001);

        // go pulses and input changes during DRAW are ignored.
        mode = 1'b0;
        colour_in = 3'b011;
        push_rect(8'd1, 7'd1, 8'd3, 7'd2, 3'b011);
        go_pulse(8'd1);
        go_pulse(8'd1);
        go_pulse(8'd3);
        go_pulse(8'd2);
        colour_in = 3'b101;
        data_in = 8'd200;
        go_pulse(8'd200);
        go_pulse(8'd200);
        wait_done("go_in_draw", 8'd3, 7'd2, 3'b011);
        mode = 1'b1;
        colour_in = 3'b110;
        push_rect(8'd40, 7'd41, 8'd40, 7'd41, 3'b110);
        go_pulse(8'd40);
        go_pulse(8'd41);
        wait_done("after_draw_go", 8'd40, 7'd41, 3'b110);

        // Reset on the third plot cycle of a 2x3 rectangle.
        mode = 1'b0;
        colour_in = 3'b110;
        exp_q.push_back('{x: 8'd2, y: 7'd3, c: 3'b110});
        exp_q.push_back('{x: 8'd3, y: 7'd3, c: 3'b110});
        exp_q.push_back('{x: 8'd4, y: 7'd3, c: 3'b110});
        go_pulse(8'd2);
        go_pulse(8'd3);
        go_pulse(8'd4);
        go_pulse(8'd4);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("mid_rst_plot", 32'(plot), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_x", 32'(x_out), 32'd0);
        chk("mid_rst_y", 32'(y_out), 32'd0);
        chk("mid_rst_c", 32'(colour_out), 32'd0);
        chk("mid_rst_sb", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        run_vec("post_reset", vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
